// File: rtl/ysyx_22050518_pkg.sv
// Shared definitions for the ysyx_22050518 load/store unit: FSM states, access sizes,
// byte-mask constants and the alignment rule.
package ysyx_22050518_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StOut
  } lsu_state_e;

  // Access size is func3[1:0]; func3[2] only selects zero/sign extension downstream.
  typedef enum logic [1:0] {
    SizeByte,
    SizeHalf,
    SizeWord,
    SizeDouble
  } mem_size_e;

  localparam logic [2:0] Func3Illegal = 3'b111;

  localparam logic [7:0] MaskByte   = 8'h01;
  localparam logic [7:0] MaskHalf   = 8'h03;
  localparam logic [7:0] MaskWord   = 8'h0F;
  localparam logic [7:0] MaskDouble = 8'hFF;

  function automatic logic [7:0] size_mask(mem_size_e size);
    logic [7:0] mask;
    unique case (size)
      SizeByte:   mask = MaskByte;
      SizeHalf:   mask = MaskHalf;
      SizeWord:   mask = MaskWord;
      SizeDouble: mask = MaskDouble;
    endcase
    return mask;
  endfunction

  function automatic logic misaligned(logic [2:0] func3, logic [2:0] off);
    logic mis;
    unique case (mem_size_e'(func3[1:0]))
      SizeByte:   mis = 1'b0;
      SizeHalf:   mis = off[0];
      SizeWord:   mis = |off[1:0];
      SizeDouble: mis = |off;
    endcase
    return mis | (func3 == Func3Illegal);
  endfunction

endpackage

// File: rtl/ysyx_22050518_lsu_if.sv
// Bus bundle of the load/store unit: execute-stage request, memory port and result port.
interface ysyx_22050518_lsu_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic            in_wen;
    logic [2:0]      in_func3;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_wdata;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_wen;
    logic [XLEN-1:0] mem_req_wdata;
    logic [7:0]      mem_req_wmask;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_rdata;

    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_func3;
    logic [XLEN-1:0] out_mrd;
    logic            out_misalign;

    // The LSU side.
    modport slave (
        input  in_valid, in_wen, in_func3, in_addr, in_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  out_ready,
        output in_ready,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output out_valid, out_func3, out_mrd, out_misalign
    );

    // The surroundings: execute stage, memory and load-extension stage.
    modport master (
        output in_valid, in_wen, in_func3, in_addr, in_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output out_ready,
        input  in_ready,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  out_valid, out_func3, out_mrd, out_misalign
    );
endinterface

// File: rtl/ysyx_22050518_lsu_align.sv
// Byte-lane alignment: store data/mask shifted into lanes, load data shifted down to bit 0,
// and the misalignment check for the incoming access.
module ysyx_22050518_lsu_align
    import ysyx_22050518_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [2:0]      func3,
    input  logic [2:0]      st_off,
    input  logic [XLEN-1:0] st_raw,
    output logic [7:0]      st_mask,
    output logic [XLEN-1:0] st_data,
    output logic            misalign,
    input  logic [2:0]      ld_off,
    input  logic [XLEN-1:0] ld_raw,
    output logic [XLEN-1:0] ld_data
);

    always_comb begin
        st_mask  = size_mask(mem_size_e'(func3[1:0])) << st_off;
        st_data  = st_raw << {st_off, 3'b000};
        misalign = misaligned(func3, st_off);
        ld_data  = ld_raw >> {ld_off, 3'b000};
    end

endmodule

// File: rtl/ysyx_22050518_lsu.sv
// Single-outstanding load/store unit: accepts one access, issues one aligned 8-byte memory
// request, waits for the response and presents the right-aligned raw result.
module ysyx_22050518_lsu
    import ysyx_22050518_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input logic                clk,
    input logic                rst_n,
    ysyx_22050518_lsu_if.slave bus
);

    lsu_state_e state;
    logic       wen_q;
    logic [2:0] off_q;

    logic [7:0]      st_mask;
    logic [XLEN-1:0] st_data;
    logic [XLEN-1:0] ld_data;
    logic            misalign;

    ysyx_22050518_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .func3   (bus.in_func3),
        .st_off  (bus.in_addr[2:0]),
        .st_raw  (bus.in_wdata),
        .st_mask (st_mask),
        .st_data (st_data),
        .misalign(misalign),
        .ld_off  (off_q),
        .ld_raw  (bus.mem_rsp_rdata),
        .ld_data (ld_data)
    );

    assign bus.in_ready = (state == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= StIdle;
            wen_q             <= 1'b0;
            off_q             <= 3'd0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
            bus.mem_req_wen   <= 1'b0;
            bus.mem_req_wdata <= '0;
            bus.mem_req_wmask <= 8'h00;
            bus.out_valid     <= 1'b0;
            bus.out_func3     <= 3'd0;
            bus.out_mrd       <= '0;
            bus.out_misalign  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.in_valid) begin
                        wen_q            <= bus.in_wen;
                        off_q            <= bus.in_addr[2:0];
                        bus.out_func3    <= bus.in_func3;
                        bus.out_mrd      <= '0;
                        bus.out_misalign <= misalign;
                        if (misalign) begin
                            // Faulting accesses never reach memory.
                            state         <= StOut;
                            bus.out_valid <= 1'b1;
                        end else begin
                            state             <= StReq;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_req_addr  <= {bus.in_addr[XLEN-1:3], 3'b000};
                            bus.mem_req_wen   <= bus.in_wen;
                            bus.mem_req_wmask <= bus.in_wen ? st_mask : 8'h00;
                            bus.mem_req_wdata <= bus.in_wen ? st_data : '0;
                        end
                    end
                end
                StReq: begin
                    if (bus.mem_req_ready) begin
                        state             <= StResp;
                        bus.mem_req_valid <= 1'b0;
                    end
                end
                StResp: begin
                    if (bus.mem_rsp_valid) begin
                        state         <= StOut;
                        bus.out_mrd   <= wen_q ? '0 : ld_data;
                        bus.out_valid <= 1'b1;
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        state         <= StIdle;
                        bus.out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050518_lsu.sv
// Self-checking bench for ysyx_22050518_lsu: directed scenarios plus randomized accesses
// compared against an arithmetic reference model and a small memory responder.
module tb_ysyx_22050518_lsu;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_22050518_lsu_if #(.XLEN(64)) bus ();

    ysyx_22050518_lsu #(.XLEN(64)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        bit          got_req;
        int          req_lat;
        logic [63:0] req_addr;
        logic        req_wen;
        logic [7:0]  req_wmask;
        logic [63:0] req_wdata;
        bit          req_stable;
        bit          extra_req;
        int          out_lat;
        logic [2:0]  out_func3;
        logic [63:0] out_mrd;
        logic        out_mis;
        bit          out_stable;
        int          completions;
        bit          post_idle;
        bit          timeout;
    } obs_t;

    // Reference model: plain arithmetic on size = 2^func3[1:0] bytes, lane = addr mod 8.
    function automatic bit m_mis(logic [2:0] f3, logic [63:0] a);
        int unsigned sz = 1 << f3[1:0];
        int unsigned lo = int'(a % 8);
        return (f3 == 3'd7) || ((lo % sz) != 0);
    endfunction

    function automatic logic [7:0] m_mask(logic [2:0] f3, logic [63:0] a);
        int unsigned sz = 1 << f3[1:0];
        int unsigned lo = int'(a % 8);
        return 8'(((1 << sz) - 1) << lo);
    endfunction

    function automatic logic [63:0] m_wdata(logic [63:0] d, logic [63:0] a);
        return d << (8 * (a % 8));
    endfunction

    function automatic logic [63:0] m_mrd(logic wen, logic [63:0] r, logic [63:0] a);
        return wen ? 64'd0 : (r >> (8 * (a % 8)));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid      = 1'b0;
        bus.in_wen        = 1'($urandom);
        bus.in_func3      = 3'($urandom);
        bus.in_addr       = {$urandom, $urandom};
        bus.in_wdata      = {$urandom, $urandom};
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = {$urandom, $urandom};
        bus.out_ready     = 1'b0;
    endtask

    // Drives one access and plays memory/consumer; returns what was observed.
    task automatic run_txn(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rdata,
                           input int req_stall, input int out_stall, input bit stray,
                           output obs_t o);
        int req_seen = 0;
        int out_seen = 0;
        bit req_done = 0;
        bit rsp_due  = 0;
        bit out_done = 0;
        o.got_req = 0; o.req_lat = -1; o.req_addr = '0; o.req_wen = 0; o.req_wmask = '0;
        o.req_wdata = '0; o.req_stable = 1; o.extra_req = 0; o.out_lat = -1; o.out_func3 = '0;
        o.out_mrd = '0; o.out_mis = 0; o.out_stable = 1; o.completions = 0; o.post_idle = 0;
        o.timeout = 0;
        bus.in_valid = 1'b1;
        bus.in_wen   = wen;
        bus.in_func3 = f3;
        bus.in_addr  = addr;
        bus.in_wdata = wdata;
        step();
        idle_inputs();
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (out_done) begin
                o.post_idle = !bus.out_valid && bus.in_ready && !bus.mem_req_valid;
                bus.out_ready     = 1'b0;
                bus.mem_rsp_valid = 1'b0;
                break;
            end
            bus.mem_rsp_valid = 1'b0;
            if (rsp_due) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_rdata = rdata;
                rsp_due = 0;
            end else if (stray && $urandom_range(1, 0) == 1) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_rdata = {$urandom, $urandom};
            end
            bus.mem_req_ready = 1'b0;
            if (bus.mem_req_valid) begin
                if (req_done) begin
                    o.extra_req = 1;
                end else begin
                    if (req_seen == 0) begin
                        o.got_req   = 1;
                        o.req_lat   = cyc;
                        o.req_addr  = bus.mem_req_addr;
                        o.req_wen   = bus.mem_req_wen;
                        o.req_wmask = bus.mem_req_wmask;
                        o.req_wdata = bus.mem_req_wdata;
                    end else if ({bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wmask,
                                  bus.mem_req_wdata} !==
                                 {o.req_addr, o.req_wen, o.req_wmask, o.req_wdata}) begin
                        o.req_stable = 0;
                    end
                    req_seen++;
                    bus.mem_req_ready = (req_seen > req_stall);
                    if (bus.mem_req_ready) begin
                        req_done = 1;
                        rsp_due  = 1;
                    end
                end
            end
            bus.out_ready = 1'b0;
            if (bus.out_valid) begin
                if (out_seen == 0) begin
                    o.completions++;
                    o.out_lat   = cyc;
                    o.out_func3 = bus.out_func3;
                    o.out_mrd   = bus.out_mrd;
                    o.out_mis   = bus.out_misalign;
                end else if ({bus.out_func3, bus.out_mrd, bus.out_misalign} !==
                             {o.out_func3, o.out_mrd, o.out_mis}) begin
                    o.out_stable = 0;
                end
                out_seen++;
                bus.out_ready = (out_seen > out_stall);
                if (bus.out_ready) out_done = 1;
            end
            step();
        end
        if (!out_done) begin
            o.timeout = 1;
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            idle_inputs();
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.in_valid = 1'b1;
        bus.in_func3 = 3'b011;
        bus.in_addr  = 64'h8000_0000;
        repeat (3) step();
        tests_run++;
        if ({bus.in_ready, bus.mem_req_valid, bus.out_valid, bus.out_misalign} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got rdy/mreq/oval/mis=%b want 1000",
                     {bus.in_ready, bus.mem_req_valid, bus.out_valid, bus.out_misalign});
        end
        tests_run++;
        if ({bus.out_mrd, bus.out_func3} !== 67'd0) begin
            tests_failed++;
            $display("FAIL reset_out: got mrd=%h f3=%0d want 0", bus.out_mrd, bus.out_func3);
        end
        tests_run++;
        if ({bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wmask} !== 137'd0)
        begin
            tests_failed++;
            $display("FAIL reset_req: got addr=%h wen=%b wdata=%h wmask=%h want 0",
                     bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wmask);
        end
        idle_inputs();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_double();
        obs_t o;
        run_txn(1'b0, 3'b011, 64'h8000_0008, 64'h0, 64'h1122_3344_5566_7788, 0, 0, 0, o);
        tests_run++;
        if ({o.got_req, o.req_addr, o.req_wen, o.req_wmask} !== {1'b1, 64'h8000_0008, 1'b0, 8'h00})
        begin
            tests_failed++;
            $display("FAIL ld_d_req: got req=%b addr=%h wen=%b wmask=%h want 1 80000008 0 00",
                     o.got_req, o.req_addr, o.req_wen, o.req_wmask);
        end
        tests_run++;
        if ({o.out_mrd, o.out_mis, o.out_func3} !== {64'h1122_3344_5566_7788, 1'b0, 3'b011}) begin
            tests_failed++;
            $display("FAIL ld_d_out: got mrd=%h mis=%b f3=%0d want 1122334455667788 0 3",
                     o.out_mrd, o.out_mis, o.out_func3);
        end
        tests_run++;
        if (o.req_lat != 1 || o.out_lat != 3 || !o.post_idle) begin
            tests_failed++;
            $display("FAIL ld_d_latency: got req@%0d out@%0d idle=%b want 1 3 1",
                     o.req_lat, o.out_lat, o.post_idle);
        end
    endtask

    task automatic test_load_byte();
        obs_t o;
        run_txn(1'b0, 3'b000, 64'h8000_0005, 64'h0, 64'h1122_3344_5566_7788, 0, 0, 0, o);
        tests_run++;
        if (o.req_addr !== 64'h8000_0000 || o.req_wmask !== 8'h00) begin
            tests_failed++;
            $display("FAIL ld_b_req: got addr=%h wmask=%h want 80000000 00",
                     o.req_addr, o.req_wmask);
        end
        tests_run++;
        if (o.out_mrd[7:0] !== 8'h33) begin
            tests_failed++;
            $display("FAIL ld_b_data: got %h want 33", o.out_mrd[7:0]);
        end
    endtask

    task automatic test_store_half();
        obs_t o;
        run_txn(1'b1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_ABCD, {$urandom, $urandom},
                0, 0, 0, o);
        tests_run++;
        if ({o.req_wen, o.req_wmask, o.req_wdata} !== {1'b1, 8'hC0, 64'hABCD_0000_0000_0000})
        begin
            tests_failed++;
            $display("FAIL st_h: got wen=%b wmask=%h wdata=%h want 1 c0 abcd000000000000",
                     o.req_wen, o.req_wmask, o.req_wdata);
        end
        tests_run++;
        if (o.out_mrd !== 64'd0 || o.out_mis !== 1'b0) begin
            tests_failed++;
            $display("FAIL st_h_out: got mrd=%h mis=%b want 0 0", o.out_mrd, o.out_mis);
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        run_txn(1'b0, 3'b010, 64'h8000_0002, 64'h0, 64'h0, 0, 0, 1, o);
        tests_run++;
        if (o.got_req || o.out_lat != 1 || o.out_mis !== 1'b1 || o.out_func3 !== 3'b010) begin
            tests_failed++;
            $display("FAIL misalign_lw: got req=%b out@%0d mis=%b f3=%0d want 0 1 1 2",
                     o.got_req, o.out_lat, o.out_mis, o.out_func3);
        end
        run_txn(1'b1, 3'b111, 64'h8000_0000, 64'h0, 64'h0, 0, 0, 0, o);
        tests_run++;
        if (o.got_req || o.out_mis !== 1'b1) begin
            tests_failed++;
            $display("FAIL misalign_f3_7: got req=%b mis=%b want 0 1", o.got_req, o.out_mis);
        end
    endtask

    task automatic test_stalls();
        obs_t o;
        logic [63:0] rd;
        bit quiet = 1;
        rd = {$urandom, $urandom};
        run_txn(1'b0, 3'b010, 64'h8000_0014, 64'h0, rd, 5, 3, 1, o);
        tests_run++;
        if (!o.req_stable || !o.out_stable) begin
            tests_failed++;
            $display("FAIL stall_stable: got req_stable=%b out_stable=%b want 1 1",
                     o.req_stable, o.out_stable);
        end
        tests_run++;
        if (o.completions != 1 || o.extra_req || o.out_lat != 8 || !o.post_idle) begin
            tests_failed++;
            $display("FAIL stall_flow: got done=%0d extra=%b out@%0d idle=%b want 1 0 8 1",
                     o.completions, o.extra_req, o.out_lat, o.post_idle);
        end
        tests_run++;
        if (o.out_mrd !== (rd >> 32)) begin
            tests_failed++;
            $display("FAIL stall_data: got %h want %h", o.out_mrd, rd >> 32);
        end
        repeat (3) begin
            step();
            if (bus.out_valid || bus.mem_req_valid) quiet = 0;
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL stall_once: got activity after completion want none");
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit quiet = 1;
        bus.in_valid = 1'b1;
        bus.in_wen   = 1'b0;
        bus.in_func3 = 3'b011;
        bus.in_addr  = 64'h8000_0040;
        step();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.mem_req_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_in_req: got mreq=%b rdy=%b want 0 1",
                     bus.mem_req_valid, bus.in_ready);
        end
        step();
        rst_n = 1'b1;
        step();
        bus.in_valid = 1'b1;
        bus.in_func3 = 3'b011;
        bus.in_addr  = 64'h8000_0048;
        step();
        idle_inputs();
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = {$urandom, $urandom};
        step();
        bus.mem_rsp_valid = 1'b0;
        repeat (3) begin
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) quiet = 0;
            step();
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL rst_in_resp: got out_valid/in_ready disturbed by stray rsp want 0/1");
        end
        run_txn(1'b0, 3'b000, 64'h8000_0007, 64'h0, 64'hAB00_0000_0000_0000, 0, 0, 0, o);
        tests_run++;
        if (o.timeout || o.out_mrd !== 64'hAB) begin
            tests_failed++;
            $display("FAIL rst_recover: got timeout=%b mrd=%h want 0 ab", o.timeout, o.out_mrd);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic        wen;
        logic [2:0]  f3;
        logic [63:0] addr, wd, rd;
        bit          mis;
        for (int n = 0; n < 60; n++) begin
            wen  = 1'($urandom_range(1, 0));
            f3   = 3'($urandom_range(7, 0));
            addr = {32'h8000_0000, $urandom};
            if ($urandom_range(3, 0) != 0) addr[2:0] = addr[2:0] & ~3'((1 << f3[1:0]) - 1);
            wd   = {$urandom, $urandom};
            rd   = {$urandom, $urandom};
            mis  = m_mis(f3, addr);
            run_txn(wen, f3, addr, wd, rd, $urandom_range(3, 0), $urandom_range(3, 0), 1, o);
            tests_run++;
            if (o.timeout || o.out_mis !== mis || o.got_req !== !mis || o.out_func3 !== f3) begin
                tests_failed++;
                $display("FAIL rnd_ctrl[%0d]: got to=%b mis=%b req=%b f3=%0d want 0 %b %b %0d",
                         n, o.timeout, o.out_mis, o.got_req, o.out_func3, mis, !mis, f3);
            end
            if (!mis) begin
                tests_run++;
                if (o.req_addr !== (addr - (addr % 8)) || o.req_wen !== wen ||
                    o.req_wmask !== (wen ? m_mask(f3, addr) : 8'h00)) begin
                    tests_failed++;
                    $display("FAIL rnd_req[%0d]: got addr=%h wen=%b wmask=%h want %h %b %h",
                             n, o.req_addr, o.req_wen, o.req_wmask, addr - (addr % 8), wen,
                             wen ? m_mask(f3, addr) : 8'h00);
                end
                tests_run++;
                if ((wen && o.req_wdata !== m_wdata(wd, addr)) ||
                    o.out_mrd !== m_mrd(wen, rd, addr)) begin
                    tests_failed++;
                    $display("FAIL rnd_data[%0d]: got wdata=%h mrd=%h want %h %h", n,
                             o.req_wdata, o.out_mrd, m_wdata(wd, addr), m_mrd(wen, rd, addr));
                end
                tests_run++;
                if (!o.req_stable || !o.out_stable || o.extra_req || o.completions != 1) begin
                    tests_failed++;
                    $display("FAIL rnd_hold[%0d]: got rs=%b os=%b extra=%b done=%0d want 1 1 0 1",
                             n, o.req_stable, o.out_stable, o.extra_req, o.completions);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        run_txn(1'b1, 3'b011, 64'h8000_0100, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 0, o);
        run_txn(1'b0, 3'b001, 64'h8000_0102, 64'h0, 64'h0000_0000_BEEF_0000, 0, 0, 0, o);
        tests_run++;
        if (o.req_lat != 1 || o.out_lat != 3 || o.out_mrd[15:0] !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL b2b: got req@%0d out@%0d mrd=%h want 1 3 ....beef",
                     o.req_lat, o.out_lat, o.out_mrd);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_double();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_stalls();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ysyx_22050518_lsu.md
YSYX_22050518_LSU -- requirements
Module: ysyx_22050518_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 64: data and address width; only 64 is supported.
REQ-002 SHALL have port clk, input, 1: single clock; all state is updated on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid/in_ready, input/output, 1/1: request handshake from the execute stage.
REQ-005 SHALL have port in_wen, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port in_func3, input, 3: RV64 load/store func3.
REQ-007 SHALL have port in_addr/in_wdata, input, 64/64: byte address and store data (store data right-aligned).
REQ-008 SHALL have port mem_req_valid/mem_req_ready, output/input, 1/1: memory request handshake.
REQ-009 SHALL have port mem_req_addr/mem_req_wen, output, 64/1: 8-byte-aligned address and write enable.
REQ-010 SHALL have port mem_req_wdata/mem_req_wmask, output, 64/8: lane-shifted store data and byte mask.
REQ-011 SHALL have port mem_rsp_valid/mem_rsp_rdata, input, 1/64: memory response (loads and stores).
REQ-012 SHALL have port out_valid/out_ready, output/input, 1/1: result handshake to the load-extension stage.
REQ-013 SHALL have port out_func3/out_mrd/out_misalign, output, 3/64/1: captured func3, right-aligned raw load data, and misalign flag.

Function
REQ-014 SHALL use FSM states IDLE, REQ, RESP and OUT; in_ready = (state == IDLE).
REQ-015 In IDLE, on in_valid, SHALL capture wen, func3, addr and wdata; on a misaligned access go to OUT with out_misalign = 1; otherwise go to REQ.
REQ-016 Misaligned SHALL mean any of: func3[1:0] = 01 with addr[0] set; func3[1:0] = 10 with addr[1:0] != 0; func3[1:0] = 11 with addr[2:0] != 0; or func3 = 111 (illegal).
REQ-017 A misaligned access SHALL never assert mem_req_valid.
REQ-018 In REQ, SHALL assert mem_req_valid with all mem_req_* held stable until mem_req_ready, then go to RESP.
REQ-019 mem_req_addr SHALL equal {addr[63:3], 3'b000}.
REQ-020 For stores, mem_req_wmask SHALL be the size mask (01/03/0F/FF for byte/half/word/double) shifted left by addr[2:0], and mem_req_wdata SHALL be wdata shifted left by 8*addr[2:0].
REQ-021 For loads, mem_req_wmask SHALL be 0.
REQ-022 In RESP, on mem_rsp_valid, SHALL register out_mrd = mem_rsp_rdata >> 8*addr[2:0] for loads (0 for stores), then go to OUT.
REQ-023 mem_rsp_valid outside RESP SHALL be ignored.
REQ-024 In OUT, SHALL hold out_valid = 1 with out_func3, out_mrd and out_misalign stable until out_ready, then go to IDLE.
REQ-025 Latency SHALL be: accept at cycle 0; mem_req_valid at cycle 1; with ready at cycle 1 and response at cycle 2, out_valid at cycle 3.
REQ-026 SHALL hold at most one transaction in flight; back-to-back accesses are separated by the OUT→IDLE return.
REQ-027 mem_req_ready and out_ready stalls of any length SHALL cause no loss or change of state.

Reset
REQ-028 While rst_n = 0, state SHALL be IDLE and mem_req_valid, out_valid, out_misalign, out_mrd, out_func3, mem_req_* SHALL all be 0; in_valid SHALL be ignored.
REQ-029 Reset mid-operation SHALL abandon the transaction immediately: mem_req_valid drops asynchronously, and any later response SHALL be ignored per REQ-023.

Structure
REQ-030 Func3 encodings, size-mask constants and FSM state encoding SHALL live in the shared ysyx_22050518 package.
REQ-031 Lane alignment (store shift/mask and load shift) SHALL be one combinational sub-module, ysyx_22050518_lsu_align.

Verification
REQ-032 Load double (func3 = 011), addr 0x80000008, rdata 0x1122334455667788 -> req addr 0x80000008, wmask 00, out_mrd 0x1122334455667788.
REQ-033 Load byte (func3 = 000), addr 0x80000005, rdata 0x1122334455667788 -> req addr 0x80000000, out_mrd[7:0] = 0x33.
REQ-034 Store half (func3 = 001), addr 0x80000006, wdata 0xABCD -> wmask C0, wdata 0xABCD000000000000.
REQ-035 Load word (func3 = 010), addr 0x80000002 -> no mem_req_valid, out_valid at cycle 1 with out_misalign = 1.
REQ-036 mem_req_ready held low 5 cycles, then out_ready held low 3 cycles -> request and result fields stable throughout; one completion only.
REQ-037 rst_n asserted while in RESP, then a stray mem_rsp_valid after release -> state IDLE, out_valid stays 0.
